// File: rtl/mealy_sequence_1011_pkg.sv
// Shared types, defaults and the elaboration-time transition function for
// the serial pattern detector.
package mealy_sequence_1011_pkg;

    localparam int unsigned MAX_SEQ_LEN     = 16;
    localparam int unsigned DEFAULT_SEQ_LEN = 4;
    localparam logic [3:0]  DEFAULT_SEQ     = 4'b1011;
    localparam int unsigned STATE_W         = 2;

    // Default-pattern states: number of pattern bits matched so far.
    typedef enum logic [STATE_W-1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    // Pattern bit in arrival order: index 0 is the first bit on the line.
    function automatic logic seq_bit(input logic [MAX_SEQ_LEN-1:0] seq,
                                     input int unsigned len,
                                     input int unsigned idx);
        return seq[4'(len - 1 - idx)];
    endfunction

    function automatic logic seq_hit(input int unsigned state,
                                     input logic bit_in,
                                     input logic [MAX_SEQ_LEN-1:0] seq,
                                     input int unsigned len);
        return (state == len - 1) && (bit_in == seq[0]);
    endfunction

    // Longest suffix of (matched prefix + bit_in) that is a proper prefix of
    // the pattern; covers advance, mismatch fallback and the KMP restart.
    function automatic int unsigned next_state(input int unsigned state,
                                               input logic bit_in,
                                               input logic [MAX_SEQ_LEN-1:0] seq,
                                               input int unsigned len,
                                               input bit overlap);
        logic [MAX_SEQ_LEN-1:0] cand;
        int unsigned            best;
        logic                   ok;
        cand = '0;
        best = 0;
        if (state < len && !(!overlap && seq_hit(state, bit_in, seq, len))) begin
            for (int unsigned i = 0; i < state; i++) begin
                cand[4'(i)] = seq_bit(seq, len, i);
            end
            cand[4'(state)] = bit_in;
            for (int unsigned m = 1; m < len; m++) begin
                if (m <= state + 1) begin
                    ok = 1'b1;
                    for (int unsigned j = 0; j < m; j++) begin
                        if (cand[4'(state + 1 - m + j)] != seq_bit(seq, len, j)) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        best = m;
                    end
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/mealy_sequence_1011.sv
// Mealy serial pattern detector: z pulses combinationally while the final
// pattern bit is on x. Transition table is fixed at elaboration.
module mealy_sequence_1011
    import mealy_sequence_1011_pkg::*;
#(
    parameter int unsigned        SEQ_LEN = DEFAULT_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] SEQ     = SEQ_LEN'(DEFAULT_SEQ),
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    localparam int unsigned SW      = $clog2(SEQ_LEN);
    localparam int unsigned NUM_ENC = 2 ** SW;

    typedef logic [2*NUM_ENC-1:0][SW-1:0] ns_tbl_t;
    typedef logic [2*NUM_ENC-1:0]         hit_tbl_t;

    // Tables are indexed by {state, x}; encodings >= SEQ_LEN map to S0, no hit.
    function automatic ns_tbl_t build_ns_tbl();
        ns_tbl_t t;
        t = '0;
        for (int unsigned k = 0; k < NUM_ENC; k++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                t[(SW+1)'(2*k + b)] =
                    SW'(next_state(k, 1'(b), 16'(SEQ), SEQ_LEN, OVERLAP));
            end
        end
        return t;
    endfunction

    function automatic hit_tbl_t build_hit_tbl();
        hit_tbl_t t;
        t = '0;
        for (int unsigned k = 0; k < NUM_ENC; k++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                t[(SW+1)'(2*k + b)] = seq_hit(k, 1'(b), 16'(SEQ), SEQ_LEN);
            end
        end
        return t;
    endfunction

    localparam ns_tbl_t  NS_TBL  = build_ns_tbl();
    localparam hit_tbl_t HIT_TBL = build_hit_tbl();

    logic [SW-1:0] state;
    logic [SW-1:0] state_next;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= '0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state lookup and Mealy output; z is suppressed while in reset.
    always_comb begin
        state_next = '0;
        z          = 1'b0;
        state_next = NS_TBL[{state, x}];
        z          = rst & HIT_TBL[{state, x}];
    end

endmodule

// File: tb/tb_mealy_sequence_1011.sv
// Scoreboard bench for mealy_sequence_1011: default, non-overlapping and a
// generic 3-bit pattern instance share clk, rst and x.
module tb_mealy_sequence_1011;
    import mealy_sequence_1011_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic x;
    logic z_def;
    logic z_nov;
    logic z_gen;

    int n_checks = 0;
    int n_fail   = 0;

    logic       exp_q [$];
    logic [2:0] rnd_q [$];

    always #5 clk = ~clk;

    mealy_sequence_1011 dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z_def)
    );

    mealy_sequence_1011 #(
        .SEQ_LEN (4),
        .SEQ     (4'b1011),
        .OVERLAP (1'b0)
    ) dut_nov (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z_nov)
    );

    mealy_sequence_1011 #(
        .SEQ_LEN (3),
        .SEQ     (3'b110),
        .OVERLAP (1'b1)
    ) dut_gen (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z_gen)
    );

    task automatic do_reset();
        rst = 1'b0;
        x   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        string s = "1011";
        string e = "0001";
        logic  exp_z;
        rst = 1'b0;
        x   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (z_def !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_z cycle %0d: z=%b expected 0", c, z_def);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (dut.state !== 2'(S0)) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: state=%0d expected %0d", c, dut.state, S0);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            x = (s[i] == "1");
            exp_q.push_back(e[i] == "1");
            @(negedge clk);
            exp_z = exp_q.pop_front();
            n_checks++;
            if (z_def !== exp_z) begin
                n_fail++;
                $display("FAIL reset_release bit %0d: z=%b expected %b", i, z_def, exp_z);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_overlap_stream();
        string s = "0101101101101";
        string e = "0000100100100";
        logic  exp_z;
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            x = (s[i] == "1");
            exp_q.push_back(e[i] == "1");
            @(negedge clk);
            exp_z = exp_q.pop_front();
            n_checks++;
            if (z_def !== exp_z) begin
                n_fail++;
                $display("FAIL overlap_stream bit %0d: z=%b expected %b", i, z_def, exp_z);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_near_misses();
        string s = "1001111010";
        logic  exp_z;
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            x = (s[i] == "1");
            exp_q.push_back(1'b0);
            @(negedge clk);
            exp_z = exp_q.pop_front();
            n_checks++;
            if (z_def !== exp_z) begin
                n_fail++;
                $display("FAIL near_miss bit %0d: z=%b expected %b", i, z_def, exp_z);
            end
            @(posedge clk);
            #1;
            if (i == 2) begin
                n_checks++;
                if (dut.state !== 2'(S0)) begin
                    n_fail++;
                    $display("FAIL near_miss_100_state: state=%0d expected %0d", dut.state, S0);
                end
            end
            if (i == 9) begin
                n_checks++;
                if (dut.state !== 2'(S2)) begin
                    n_fail++;
                    $display("FAIL near_miss_1010_state: state=%0d expected %0d", dut.state, S2);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pattern();
        string pre  = "101";
        string post = "0111011";
        string e    = "0000001";
        logic  exp_z;
        do_reset();
        for (int i = 0; i < pre.len(); i++) begin
            x = (pre[i] == "1");
            exp_q.push_back(1'b0);
            @(negedge clk);
            exp_z = exp_q.pop_front();
            n_checks++;
            if (z_def !== exp_z) begin
                n_fail++;
                $display("FAIL mid_reset_prefix bit %0d: z=%b expected %b", i, z_def, exp_z);
            end
            @(posedge clk);
            #1;
        end
        // State is S3 with x=1 here, so only the reset gate keeps z low.
        rst = 1'b0;
        x   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (z_def !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_gate: z=%b expected 0", z_def);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        n_checks++;
        if (dut.state !== 2'(S0)) begin
            n_fail++;
            $display("FAIL mid_reset_state: state=%0d expected %0d", dut.state, S0);
        end
        for (int i = 0; i < post.len(); i++) begin
            x = (post[i] == "1");
            exp_q.push_back(e[i] == "1");
            @(negedge clk);
            exp_z = exp_q.pop_front();
            n_checks++;
            if (z_def !== exp_z) begin
                n_fail++;
                $display("FAIL mid_reset_restart bit %0d: z=%b expected %b", i, z_def, exp_z);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_no_overlap();
        string s1  = "1011011";
        string e1n = "0001000";
        string e1o = "0001001";
        string s2  = "10111011";
        string e2n = "00010001";
        logic  exp_z;
        // The shared '1' at index 3 may only be reused by the overlapping instance.
        do_reset();
        for (int i = 0; i < s1.len(); i++) begin
            x = (s1[i] == "1");
            exp_q.push_back(e1n[i] == "1");
            exp_q.push_back(e1o[i] == "1");
            @(negedge clk);
            exp_z = exp_q.pop_front();
            n_checks++;
            if (z_nov !== exp_z) begin
                n_fail++;
                $display("FAIL no_overlap_a bit %0d: z=%b expected %b", i, z_nov, exp_z);
            end
            exp_z = exp_q.pop_front();
            n_checks++;
            if (z_def !== exp_z) begin
                n_fail++;
                $display("FAIL overlap_contrast bit %0d: z=%b expected %b", i, z_def, exp_z);
            end
            @(posedge clk);
            #1;
        end
        do_reset();
        for (int i = 0; i < s2.len(); i++) begin
            x = (s2[i] == "1");
            exp_q.push_back(e2n[i] == "1");
            @(negedge clk);
            exp_z = exp_q.pop_front();
            n_checks++;
            if (z_nov !== exp_z) begin
                n_fail++;
                $display("FAIL no_overlap_b bit %0d: z=%b expected %b", i, z_nov, exp_z);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_generic_pattern();
        string s = "1110110";
        string e = "0001001";
        logic  exp_z;
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            x = (s[i] == "1");
            exp_q.push_back(e[i] == "1");
            @(negedge clk);
            exp_z = exp_q.pop_front();
            n_checks++;
            if (z_gen !== exp_z) begin
                n_fail++;
                $display("FAIL generic_110 bit %0d: z=%b expected %b", i, z_gen, exp_z);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Window-compare model over a random stream for all three instances.
    task automatic test_random();
        logic [2:0] hist;
        logic [3:0] win;
        logic [2:0] exp_v;
        int         since_nov;
        logic       xb;
        do_reset();
        hist      = '0;
        since_nov = 0;
        for (int i = 0; i < 400; i++) begin
            xb  = 1'($urandom_range(1, 0));
            x   = xb;
            win = {hist, xb};
            exp_v[0] = (win == 4'b1011);
            exp_v[1] = (win == 4'b1011) && (since_nov >= 3);
            exp_v[2] = (win[2:0] == 3'b110);
            rnd_q.push_back(exp_v);
            since_nov = exp_v[1] ? 0 : ((since_nov < 8) ? since_nov + 1 : since_nov);
            hist      = win[2:0];
            @(negedge clk);
            exp_v = rnd_q.pop_front();
            n_checks++;
            if ({z_gen, z_nov, z_def} !== exp_v) begin
                n_fail++;
                $display("FAIL random bit %0d: {gen,nov,def}=%b expected %b", i, {z_gen, z_nov, z_def}, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0;
        x   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_overlap_stream();
        test_near_misses();
        test_reset_mid_pattern();
        test_no_overlap();
        test_generic_pattern();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
